// File: rtl/serial_add_unit.sv
// serial_add_unit
//   Bit-serial WIDTH-bit add/subtract unit. One operand bit pair is resolved
//   per clock through a single full-adder cell built from two half-adder
//   stages and a carry OR. The operation runs start edge -> WIDTH edges ->
//   one-cycle done pulse -> idle. The issue interval is WIDTH+2 cycles.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous, active-high reset (priority over everything)
//   start  : request, sampled only while idle
//   Sub    : 0 = A+B+Cin, 1 = A-B (A + ~B + 1), latched at start
//   A, B   : operands, latched at start
//   Cin    : carry-in for add, ignored for subtract, latched at start
//   busy   : high while bits are being resolved
//   done   : one-cycle pulse, Sum and flags valid
//   Sum    : result, held from done until the next completed operation
//   Cout   : final carry (subtract: 1 = no borrow)
//   Z/N/V  : zero, negative, signed-overflow flags
module serial_add_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Z,
   output logic             N,
   output logic             V
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;

   logic             is_last;
   logic             ha1_s, ha1_c;
   logic             ha2_s, ha2_c;
   logic             fa_c;

   assign is_last = (cnt_q == CW'(WIDTH - 1));

   // Full-adder cell on the current LSBs of the operand shift registers.
   always_comb begin
      ha1_s = a_q[0] ^ b_q[0];
      ha1_c = a_q[0] & b_q[0];
      ha2_s = ha1_s ^ carry_q;
      ha2_c = ha1_s & carry_q;
      fa_c  = ha1_c | ha2_c;
   end

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (is_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values.
   always_comb begin
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = Sub ? ~B : B;
               carry_d = Sub | Cin;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            res_d   = {ha2_s, res_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (is_last) begin
               cnt_d  = '0;
               sum_d  = res_d;
               cout_d = fa_c;
               z_d    = (res_d == '0);
               n_d    = ha2_s;
               // carry_q here is the carry into the MSB.
               v_d    = carry_q ^ fa_c;
            end
         end
         default: ;
      endcase
   end

   // Outputs.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign Z    = z_q;
   assign N    = n_q;
   assign V    = v_q;

endmodule

// File: tb/tb_serial_add_unit.sv
module tb_serial_add_unit;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         Sub;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Z;
   logic         N;
   logic         V;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_add_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Sub   (Sub),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout),
      .Z     (Z),
      .N     (N),
      .V     (V)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start for one edge, then scrambles the operand inputs so that
   // any failure to latch them shows up in the result.
   task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
      Sub   = sub;
      A     = a;
      B     = b;
      Cin   = cin;
      start = 1'b1;
      tick();
      start = 1'b0;
      Sub   = ~sub;
      A     = ~a;
      B     = ~b;
      Cin   = ~cin;
   endtask

   // Runs one operation and observes 11 samples after the start edge.
   // With inject set, start is re-asserted (with different operands) during
   // RUN and during DONE; neither may launch a second operation.
   task automatic run_op(input string tag, input logic sub, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic [W-1:0] e_sum,
                         input logic e_c, input logic e_z, input logic e_n, input logic e_v,
                         input bit inject);
      logic [W-1:0] prev_sum;
      logic [W-1:0] g_sum;
      logic         g_c, g_z, g_n, g_v;
      int           lat, busy_n, done_n;
      bit           stable;
      prev_sum = Sum;
      g_sum    = 'x;
      g_c      = 1'bx;
      g_z      = 1'bx;
      g_n      = 1'bx;
      g_v      = 1'bx;
      lat      = -1;
      busy_n   = 0;
      done_n   = 0;
      stable   = 1'b1;
      issue(sub, a, b, cin);
      for (int i = 0; i < 11; i++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat < 0) begin
               lat   = i;
               g_sum = Sum;
               g_c   = Cout;
               g_z   = Z;
               g_n   = N;
               g_v   = V;
            end
         end else if (lat < 0 && Sum !== prev_sum) begin
            stable = 1'b0;
         end
         if (inject) begin
            start = (i == 2 || i == 8);
            if (start) begin
               A   = 8'hFF;
               B   = 8'hFF;
               Sub = 1'b0;
            end
         end
         tick();
      end
      start = 1'b0;
      check({tag, " latency"}, lat, 8);
      check({tag, " busy_cycles"}, busy_n, 8);
      check({tag, " done_cycles"}, done_n, 1);
      check({tag, " sum_held"}, stable, 1);
      check({tag, " Sum"}, g_sum, e_sum);
      check({tag, " Cout"}, g_c, e_c);
      check({tag, " Z"}, g_z, e_z);
      check({tag, " N"}, g_n, e_n);
      check({tag, " V"}, g_v, e_v);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " Sum"}, Sum, 0);
      check({tag, " flags"}, {Cout, Z, N, V}, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, bb, es;
      logic         rs, rc, ev;
      logic [W:0]   t;
      int           done_n, first, last_at, gap_bad;

      rst   = 1'b1;
      start = 1'b0;
      Sub   = 1'b0;
      A     = '0;
      B     = '0;
      Cin   = 1'b0;
      tick();
      tick();
      check_cleared("reset");
      rst = 1'b0;
      tick();

      //        tag        sub   A      B      Cin   Sum    C     Z     N     V
      run_op("add0F01",  1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("addFF01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("add7F00c", 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_op("sub0507",  1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("sub8001",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op("sub3333",  1'b1, 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("ignore",   1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Abort in the middle of RUN.
      issue(1'b0, 8'hAA, 8'h55, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_cleared("abort");
      done_n = 0;
      for (int i = 0; i < 10; i++) begin
         if (done || busy) done_n++;
         tick();
      end
      check("abort no_activity", done_n, 0);
      run_op("afterabort", 1'b0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Continuous start: a new op every 10 cycles.
      Sub   = 1'b0;
      A     = 8'h01;
      B     = 8'h02;
      Cin   = 1'b0;
      start = 1'b1;
      done_n  = 0;
      first   = -1;
      last_at = -1;
      gap_bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) begin
            done_n++;
            if (first < 0) first = i;
            else if (i - last_at != 10) gap_bad++;
            last_at = i;
         end
      end
      start = 1'b0;
      tick();
      tick();
      check("b2b done_count", done_n, 4);
      check("b2b first_done", first, 8);
      check("b2b interval", gap_bad, 0);
      check("b2b Sum", Sum, 8'h03);
      check("b2b idle", busy, 0);

      // Random sweep against an arithmetic reference.
      for (int n = 0; n < 200; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         bb = rs ? ~rb : rb;
         t  = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rs | rc)};
         es = t[W-1:0];
         ev = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
         run_op($sformatf("rnd%0d", n), rs, ra, rb, rc, es, t[W], (es == '0), es[W-1], ev, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
